mmio_slot_arbiter: RTL and testbench

//  Shares one MMIO slot interface (address/wr_data/rd_data/read/write/cs) among
//  NUM_REQ bus requesters, e.g. CPU and DMA engine contending for a GPI/GPO core.

---
 rtl/mmio_slot_arbiter.sv | 148 ++++++++++++++
 tb/tb_mmio_slot_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_slot_arbiter.sv
// Purpose: round-robin share of one MMIO slot among NUM_REQ requesters, one single-cycle strobe per transaction.
// Latency: grant edge -> slot strobe the next cycle -> one-hot response the cycle after (1 transaction / 3 cycles).
// Backpressure: requesters hold req_* until their req_ready pulse; req_valid is only sampled while IDLE.
module mmio_slot_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ-1:0]        req_write_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]         rsp_rdata_o,
  output logic [ADDR_W-1:0]         address_o,
  output logic [DATA_W-1:0]         wr_data_o,
  output logic                      read_o,
  output logic                      write_o,
  output logic                      cs_o,
  input  logic [DATA_W-1:0]         rd_data_i
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   gnt_q, gnt_d;

  // Every output is a flop; *_d is what the flop takes at the next edge.
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic [ADDR_W-1:0]  address_q, address_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic               read_q, read_d;
  logic               write_q, write_d;
  logic               cs_q, cs_d;

  logic               grant_vld;
  logic [IDX_W-1:0]   grant_idx;

  // Round-robin search: first valid requester at or above rr_ptr_q, wrapping around.
  always_comb begin
    logic [IDX_W-1:0] cand_idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_idx = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!grant_vld && req_valid_i[cand_idx]) begin
        grant_vld = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  // Next-state and registered-output decode; outputs default to 0 outside their phase.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = gnt_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    address_d   = '0;
    wr_data_d   = '0;
    read_d      = 1'b0;
    write_d     = 1'b0;
    cs_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          state_d     = ISSUE;
          gnt_d       = grant_idx;
          req_ready_d = NUM_REQ'(1) << grant_idx;
          cs_d        = 1'b1;
          write_d     = req_write_i[grant_idx];
          read_d      = ~req_write_i[grant_idx];
          address_d   = req_addr_i[int'(grant_idx)*ADDR_W +: ADDR_W];
          wr_data_d   = req_write_i[grant_idx] ? req_wdata_i[int'(grant_idx)*DATA_W +: DATA_W]
                                               : '0;
        end
      end
      ISSUE: begin
        // rd_data is combinational from the slot during the strobe; capture it now.
        state_d     = RESP;
        rsp_valid_d = NUM_REQ'(1) << gnt_q;
        rsp_rdata_d = write_q ? '0 : rd_data_i;
      end
      RESP: begin
        // No grant here: req_valid is ignored until back in IDLE.
        state_d  = IDLE;
        rr_ptr_d = (gnt_q == IDX_W'(NUM_REQ-1)) ? '0 : gnt_q + 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; async reset aborts any transaction in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      address_q   <= '0;
      wr_data_q   <= '0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      cs_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_q       <= gnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      address_q   <= address_d;
      wr_data_q   <= wr_data_d;
      read_q      <= read_d;
      write_q     <= write_d;
      cs_q        <= cs_d;
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign address_o   = address_q;
  assign wr_data_o   = wr_data_q;
  assign read_o      = read_q;
  assign write_o     = write_q;
  assign cs_o        = cs_q;

endmodule

// File: tb/tb_mmio_slot_arbiter.sv
// Bench for mmio_slot_arbiter with four requesters: directed scenarios plus randomized traffic.
// Expected outputs come from a transaction-level model that schedules each grant's strobe and response.
// The slot is modelled as a register file with combinational read data.
module tb_mmio_slot_arbiter;

  localparam int N  = 4;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready_o;
  logic [N-1:0]    rsp_valid_o;
  logic [DW-1:0]   rsp_rdata_o;
  logic [AW-1:0]   address_o;
  logic [DW-1:0]   wr_data_o;
  logic            read_o;
  logic            write_o;
  logic            cs_o;
  logic [DW-1:0]   rd_data;

  mmio_slot_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_write_i (req_write),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_ready_o (req_ready_o),
    .rsp_valid_o (rsp_valid_o),
    .rsp_rdata_o (rsp_rdata_o),
    .address_o   (address_o),
    .wr_data_o   (wr_data_o),
    .read_o      (read_o),
    .write_o     (write_o),
    .cs_o        (cs_o),
    .rd_data_i   (rd_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Slot register file: power-up contents from init_val until first written.
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return (a == 5'd3) ? 32'h0000A5A5 : (32'hC0DE0000 | {27'b0, a});
  endfunction

  logic [DW-1:0] slot_mem [32];
  logic [31:0]   slot_wr = '0;
  assign rd_data = slot_wr[address_o] ? slot_mem[address_o] : init_val(address_o);

  always @(posedge clk) begin
    if (cs_o && write_o) begin
      slot_mem[address_o] <= wr_data_o;
      slot_wr[address_o]  <= 1'b1;
    end
  end

  // Requester-side state driven by the bench.
  logic [N-1:0]  r_vld;
  logic [N-1:0]  r_wr;
  logic [AW-1:0] r_addr [N];
  logic [DW-1:0] r_wd   [N];
  logic [N-1:0]  acc;

  // Reference model: round-robin pointer, earliest cycle it may grant, memory image,
  // and a ring of expected outputs indexed by cycle.
  int            cyc;
  int            rr;
  int            idle_from;
  logic [DW-1:0] model_mem [32];
  logic [N-1:0]  x_rdy   [8];
  logic [N-1:0]  x_rspv  [8];
  logic [DW-1:0] x_rdata [8];
  logic          x_cs    [8];
  logic          x_rd    [8];
  logic          x_wr    [8];
  logic [AW-1:0] x_addr  [8];
  logic [DW-1:0] x_wd    [8];

  int            n_cmp;
  int            n_err;
  int            dut_grants[$];
  logic [N-1:0]  last_rspv;
  logic [DW-1:0] last_rsp;
  logic [DW-1:0] last_wd;
  logic [AW-1:0] last_wa;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int from, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  task automatic clear_slot(input int e);
    x_rdy[e] = '0; x_rspv[e] = '0; x_rdata[e] = '0; x_cs[e] = 1'b0;
    x_rd[e] = 1'b0; x_wr[e] = 1'b0; x_addr[e] = '0; x_wd[e] = '0;
  endtask

  task automatic model_reset();
    for (int e = 0; e < 8; e++) clear_slot(e);
    rr = 0;
    idle_from = 0;
    acc = '0;
  endtask

  // Called with the inputs that the next rising edge will sample.
  task automatic model_eval();
    int g;
    int e1;
    int e2;
    if (cyc >= idle_from && r_vld != '0) begin
      g  = pick(rr, r_vld);
      e1 = (cyc + 1) % 8;
      e2 = (cyc + 2) % 8;
      x_rdy[e1]  = N'(1) << g;
      x_cs[e1]   = 1'b1;
      x_rd[e1]   = ~r_wr[g];
      x_wr[e1]   = r_wr[g];
      x_addr[e1] = r_addr[g];
      x_wd[e1]   = r_wr[g] ? r_wd[g] : '0;
      x_rspv[e2] = N'(1) << g;
      x_rdata[e2] = r_wr[g] ? '0 : model_mem[r_addr[g]];
      if (r_wr[g]) model_mem[r_addr[g]] = r_wd[g];
      rr = (g + 1) % N;
      idle_from = cyc + 3;
      acc[g] = 1'b1;
    end
  endtask

  task automatic check_cycle();
    int e;
    e = cyc % 8;
    chk("req_ready", 64'(req_ready_o), 64'(x_rdy[e]));
    chk("rsp_valid", 64'(rsp_valid_o), 64'(x_rspv[e]));
    chk("rsp_rdata", 64'(rsp_rdata_o), 64'(x_rdata[e]));
    chk("cs",        64'(cs_o),        64'(x_cs[e]));
    chk("read",      64'(read_o),      64'(x_rd[e]));
    chk("write",     64'(write_o),     64'(x_wr[e]));
    chk("address",   64'(address_o),   64'(x_addr[e]));
    chk("wr_data",   64'(wr_data_o),   64'(x_wd[e]));
    chk("rd_wr_excl", 64'(read_o & write_o), 64'(0));
    for (int i = 0; i < N; i++) if (req_ready_o[i] === 1'b1) dut_grants.push_back(i);
    if (rsp_valid_o != '0) begin last_rspv = rsp_valid_o; last_rsp = rsp_rdata_o; end
    if (cs_o && write_o) begin last_wd = wr_data_o; last_wa = address_o; end
    clear_slot(e);
  endtask

  task automatic pack_inputs();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = r_vld[i];
      req_write[i] = r_wr[i];
      req_addr[i*AW +: AW]  = r_addr[i];
      req_wdata[i*DW +: DW] = r_wd[i];
    end
  endtask

  task automatic step();
    pack_inputs();
    model_eval();
    @(negedge clk);
    cyc++;
    check_cycle();
  endtask

  task automatic new_fields(input int i);
    r_wr[i]   = 1'($urandom);
    r_addr[i] = AW'($urandom);
    r_wd[i]   = $urandom;
  endtask

  // Granted requesters take their hold[] value and fresh fields; others keep theirs.
  task automatic run(input int n, input logic [N-1:0] hold);
    for (int s = 0; s < n; s++) begin
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          acc[i] = 1'b0;
          r_vld[i] = hold[i];
          new_fields(i);
        end
      end
      step();
    end
  endtask

  task automatic run_random(input int n);
    for (int s = 0; s < n; s++) begin
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          acc[i] = 1'b0;
          r_vld[i] = ($urandom % 3) == 0;
          new_fields(i);
        end else if (!r_vld[i]) begin
          if (($urandom % 4) == 0) begin r_vld[i] = 1'b1; new_fields(i); end
        end else if (($urandom % 20) == 0) begin
          r_vld[i] = 1'b0;
        end
      end
      step();
    end
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    r_vld = '0;
    model_reset();
    step();
    #1 rst_n = 1'b1;
    dut_grants.delete();
  endtask

  task automatic chk_order(input string tag, input int q[$]);
    chk({tag, "_count"}, 64'(dut_grants.size()), 64'(q.size()));
    for (int k = 0; k < q.size(); k++)
      chk(tag, (k < dut_grants.size()) ? 64'(dut_grants[k]) : 64'hFFFF, 64'(q[k]));
  endtask

  initial begin
    int q[$];
    n_cmp = 0; n_err = 0; cyc = 0;
    last_rspv = '0; last_rsp = '0; last_wd = '0; last_wa = '0;
    r_vld = '0; r_wr = '0;
    for (int i = 0; i < N; i++) begin r_addr[i] = '0; r_wd[i] = '0; end
    for (int a = 0; a < 32; a++) model_mem[a] = init_val(AW'(a));
    model_reset();
    pack_inputs();

    // Reset state, observed before any clock edge.
    rst_n = 1'b0;
    #2;
    chk("rst_cs", 64'(cs_o), 64'(0));
    chk("rst_read", 64'(read_o), 64'(0));
    chk("rst_write", 64'(write_o), 64'(0));
    chk("rst_ready", 64'(req_ready_o), 64'(0));
    chk("rst_rspv", 64'(rsp_valid_o), 64'(0));
    chk("rst_rdata", 64'(rsp_rdata_o), 64'(0));
    chk("rst_addr", 64'(address_o), 64'(0));
    chk("rst_wdata", 64'(wr_data_o), 64'(0));
    step();
    #1 rst_n = 1'b1;

    // Single read from requester 0, address 3.
    r_wr[0] = 1'b0; r_addr[0] = 5'd3; r_vld = 4'b0001;
    run(5, 4'b0000);
    chk("t1_rspv", 64'(last_rspv), 64'(4'b0001));
    chk("t1_rdata", 64'(last_rsp), 64'h0000A5A5);

    // Write from requester 1: address 7, 0xDEADBEEF.
    r_wr[1] = 1'b1; r_addr[1] = 5'd7; r_wd[1] = 32'hDEADBEEF; r_vld = 4'b0010;
    run(5, 4'b0000);
    chk("t2_wdata", 64'(last_wd), 64'hDEADBEEF);
    chk("t2_waddr", 64'(last_wa), 64'(7));
    chk("t2_rspv", 64'(last_rspv), 64'(4'b0010));
    chk("t2_rdata", 64'(last_rsp), 64'(0));

    // Withdrawal: requester 0 raises and drops req_valid while requester 1 is in flight.
    dut_grants.delete();
    r_wr[1] = 1'b0; r_addr[1] = 5'd5; r_vld = 4'b0010;
    step();
    acc[1] = 1'b0; r_vld[1] = 1'b0;
    r_vld[0] = 1'b1; r_wr[0] = 1'b1; r_addr[0] = 5'd2; r_wd[0] = 32'h11112222;
    step();
    r_vld[0] = 1'b0;
    run(5, 4'b0000);
    q = '{1};
    chk_order("t6_grants", q);

    // Two requesters continuously valid: alternating grants, strobes 3 cycles apart.
    do_reset();
    r_vld = 4'b0011; new_fields(0); new_fields(1);
    run(12, 4'b0011);
    r_vld = '0;
    run(3, 4'b0000);
    q = '{0, 1, 0, 1};
    chk_order("t3_grants", q);

    // All four continuously valid: 0,1,2,3,0.
    do_reset();
    r_vld = 4'b1111;
    for (int i = 0; i < N; i++) new_fields(i);
    run(15, 4'b1111);
    r_vld = '0;
    run(3, 4'b0000);
    q = '{0, 1, 2, 3, 0};
    chk_order("t4_rotate", q);

    // After grant 1, only requester 3 remains: it is next.
    do_reset();
    r_vld = 4'b0011; new_fields(0); new_fields(1);
    run(4, 4'b0011);
    r_vld = 4'b1000; new_fields(3);
    run(6, 4'b0000);
    q = '{0, 1, 3};
    chk_order("t4_insert3", q);

    // Reset asserted during ISSUE of requester 2 (pointer already at 2).
    do_reset();
    r_wr[1] = 1'b0; r_addr[1] = 5'd1; r_vld = 4'b0010;
    run(4, 4'b0000);
    r_wr[2] = 1'b0; r_addr[2] = 5'd9; r_vld = 4'b0100;
    step();
    chk("t5_cs_before", 64'(cs_o), 64'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("t5_cs_async", 64'(cs_o), 64'(0));
    chk("t5_read_async", 64'(read_o), 64'(0));
    chk("t5_write_async", 64'(write_o), 64'(0));
    chk("t5_ready_async", 64'(req_ready_o), 64'(0));
    chk("t5_addr_async", 64'(address_o), 64'(0));
    r_vld = '0;
    model_reset();
    step();
    #1 rst_n = 1'b1;
    dut_grants.delete();
    r_vld = 4'b1111;
    for (int i = 0; i < N; i++) new_fields(i);
    run(3, 4'b0000);
    q = '{0};
    chk_order("t5_first_grant", q);
    r_vld = '0;
    run(4, 4'b0000);

    // Randomized traffic against the model.
    run_random(400);
    r_vld = '0;
    run(4, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
